mc_main_fsm: RTL and testbench

//  Multicycle control state machine. Sequences fetch/decode/execute for the data-processing, LDR/STR and B

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_retire_counter.sv | 24 ++
 rtl/mc_main_fsm.sv | 153 +++++++++++++++
 tb/tb_mc_main_fsm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, datapath
// mux select codes, instruction class codes and the bundled control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_UNDEF  = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] OP_DP       = 2'b00;
    localparam logic [1:0] OP_MEM      = 2'b01;
    localparam logic [1:0] OP_BR       = 2'b10;
    localparam logic [1:0] OP_UNDEF    = 2'b11;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       illegal;
        logic       retire;
    } ctrl_t;

    // Control word with every enable low and selects parked at the fetch values.
    function automatic ctrl_t fetch_idle_ctrl();
        ctrl_t c;
        c           = '0;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALU;
        return c;
    endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter: synchronous clear, increments on en, wraps
// naturally modulo 2**CNT_W.
module mc_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle fetch/decode/execute controller producing datapath selects and
// unconditioned write requests, with memory-ready stalls and retire counting.
module mc_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             IllegalOp,
    output logic             Retire,
    output logic [CNT_W-1:0] RetireCount
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    // Funct[4:1] only matter to the ALU decoder, not to sequencing.
    logic funct_unused;
    assign funct_unused = ^Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_DP:   state_next = Funct[5] ? S_EXEI : S_EXER;
                    OP_MEM:  state_next = S_MEMADR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_UNDEF;
                endcase
            end
            S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXER:   state_next = S_ALUWB;
            S_EXEI:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_UNDEF:  state_next = HALT_ON_UNDEF ? S_UNDEF : S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_reg)
            S_FETCH: begin
                ctrl         = fetch_idle_ctrl();
                ctrl.irwrite = MemReady;
                ctrl.nextpc  = MemReady;
            end
            S_DECODE: ctrl = fetch_idle_ctrl();
            S_MEMADR: begin
                ctrl.alusrca = SRCA_RN;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regw      = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_MEMWR: begin
                // The write request is held for the whole stall; retire only
                // when memory accepts it.
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.memw      = 1'b1;
                ctrl.retire    = MemReady;
            end
            S_EXER: begin
                ctrl.alusrca = SRCA_RN;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = 1'b1;
            end
            S_EXEI: begin
                ctrl.alusrca = SRCA_RN;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = 1'b1;
            end
            S_ALUWB: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regw      = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca   = SRCA_ALUOUT;
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALU;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_UNDEF:  ctrl.illegal = 1'b1;
            default:  ctrl = '0;
        endcase
        // Reset abandons whatever is in flight: no writes, no retire.
        if (reset) begin
            ctrl = fetch_idle_ctrl();
        end
    end

    assign IRWrite   = ctrl.irwrite;
    assign NextPC    = ctrl.nextpc;
    assign AdrSrc    = ctrl.adrsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUOp     = ctrl.aluop;
    assign RegW      = ctrl.regw;
    assign MemW      = ctrl.memw;
    assign Branch    = ctrl.branch;
    assign IllegalOp = ctrl.illegal;
    assign Retire    = ctrl.retire;

    mc_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .srst  (reset),
        .en    (ctrl.retire),
        .count (RetireCount)
    );

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: expected per-cycle control words are built from the
// instruction-level cycle table of each class, then compared cycle by cycle.
module tb_mc_main_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mr;

    logic        irw, npc, adr, aluop, regw, memw, br, ill, ret;
    logic [1:0]  a, b, res;
    logic [3:0]  cnt;
    logic        h_irw, h_npc, h_adr, h_aluop, h_regw, h_memw, h_br, h_ill, h_ret;
    logic [1:0]  h_a, h_b, h_res;
    logic [31:0] h_cnt;

    always #5 clk = ~clk;

    mc_main_fsm #(.CNT_W(4), .HALT_ON_UNDEF(1'b0)) dut (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mr),
        .IRWrite(irw), .NextPC(npc), .AdrSrc(adr), .ALUSrcA(a), .ALUSrcB(b),
        .ResultSrc(res), .ALUOp(aluop), .RegW(regw), .MemW(memw), .Branch(br),
        .IllegalOp(ill), .Retire(ret), .RetireCount(cnt)
    );

    mc_main_fsm #(.CNT_W(32), .HALT_ON_UNDEF(1'b1)) dut_h (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mr),
        .IRWrite(h_irw), .NextPC(h_npc), .AdrSrc(h_adr), .ALUSrcA(h_a), .ALUSrcB(h_b),
        .ResultSrc(h_res), .ALUOp(h_aluop), .RegW(h_regw), .MemW(h_memw), .Branch(h_br),
        .IllegalOp(h_ill), .Retire(h_ret), .RetireCount(h_cnt)
    );

    wire [14:0] obs   = {irw, npc, adr, a, b, res, aluop, regw, memw, br, ill, ret};
    wire [14:0] h_obs = {h_irw, h_npc, h_adr, h_a, h_b, h_res, h_aluop, h_regw, h_memw, h_br, h_ill, h_ret};

    localparam logic [14:0] RST_V   = {3'b000, 2'b01, 2'b10, 2'b10, 6'b000000};
    localparam logic [14:0] UNDEF_V = {13'b0, 1'b1, 1'b0};

    typedef struct {
        logic        mr;
        logic [14:0] v;
    } cyc_t;

    cyc_t  plan[$];
    int    checks = 0;
    int    errors = 0;
    int    cnt_m  = 0;
    bit    h_stuck = 1'b0;
    string tag;

    function automatic logic [14:0] vec(input logic irw_e, npc_e, adr_e,
                                        input logic [1:0] a_e, b_e, res_e,
                                        input logic aluop_e, regw_e, memw_e, br_e, ill_e, ret_e);
        return {irw_e, npc_e, adr_e, a_e, b_e, res_e, aluop_e, regw_e, memw_e, br_e, ill_e, ret_e};
    endfunction

    task automatic check(input string name, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, o, e);
        end
    endtask

    task automatic push(input logic m, input logic [14:0] v);
        cyc_t c;
        c.mr = m;
        c.v  = v;
        plan.push_back(c);
    endtask

    // Cycle table of one instruction: fetch wait cycles, decode, then the class body.
    task automatic build(input logic [1:0] o, input logic [5:0] f, input int wf, input int wm);
        for (int i = 0; i < wf; i++) push(1'b0, vec(0,0,0, 2'b01,2'b10,2'b10, 0,0,0,0,0,0));
        push(1'b1, vec(1,1,0, 2'b01,2'b10,2'b10, 0,0,0,0,0,0));
        push(1'($urandom_range(0,1)), vec(0,0,0, 2'b01,2'b10,2'b10, 0,0,0,0,0,0));
        case (o)
            2'b00: begin
                push(1'($urandom_range(0,1)), vec(0,0,0, 2'b00, f[5] ? 2'b01 : 2'b00, 2'b00, 1,0,0,0,0,0));
                push(1'($urandom_range(0,1)), vec(0,0,0, 2'b00,2'b00,2'b00, 0,1,0,0,0,1));
            end
            2'b01: begin
                push(1'($urandom_range(0,1)), vec(0,0,0, 2'b00,2'b01,2'b00, 0,0,0,0,0,0));
                if (f[0]) begin
                    for (int i = 0; i < wm; i++) push(1'b0, vec(0,0,1, 2'b00,2'b00,2'b00, 0,0,0,0,0,0));
                    push(1'b1, vec(0,0,1, 2'b00,2'b00,2'b00, 0,0,0,0,0,0));
                    push(1'($urandom_range(0,1)), vec(0,0,0, 2'b00,2'b00,2'b01, 0,1,0,0,0,1));
                end else begin
                    for (int i = 0; i < wm; i++) push(1'b0, vec(0,0,1, 2'b00,2'b00,2'b00, 0,0,1,0,0,0));
                    push(1'b1, vec(0,0,1, 2'b00,2'b00,2'b00, 0,0,1,0,0,1));
                end
            end
            2'b10: push(1'($urandom_range(0,1)), vec(0,0,0, 2'b10,2'b01,2'b10, 0,0,0,1,0,1));
            default: push(1'($urandom_range(0,1)), UNDEF_V);
        endcase
    endtask

    task automatic run(input int maxc);
        cyc_t c;
        int   n;
        n = 0;
        while (plan.size() > 0 && n < maxc) begin
            c     = plan.pop_front();
            reset = 1'b0;
            mr    = c.mr;
            @(negedge clk);
            check($sformatf("%s c%0d outputs", tag, n), {17'b0, obs}, {17'b0, c.v});
            check($sformatf("%s c%0d count", tag, n), {28'b0, cnt}, 32'(cnt_m));
            check($sformatf("%s c%0d halt_dut", tag, n), {17'b0, h_obs},
                  {17'b0, (h_stuck ? UNDEF_V : c.v)});
            if (c.v[1]) h_stuck = 1'b1;
            if (c.v[0]) cnt_m = (cnt_m + 1) % 16;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input string name, input logic [1:0] o, input logic [5:0] f,
                         input int wf, input int wm);
        tag   = name;
        op    = o;
        funct = f;
        build(o, f, wf, wm);
        run(1000);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            mr    = 1'($urandom_range(0,1));
            op    = 2'($urandom_range(0,3));
            @(negedge clk);
            check($sformatf("reset%0d outputs", i), {17'b0, obs}, {17'b0, RST_V});
            check($sformatf("reset%0d halt_dut", i), {17'b0, h_obs}, {17'b0, RST_V});
            if (i > 0) check($sformatf("reset%0d count", i), {28'b0, cnt}, 32'd0);
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        cnt_m   = 0;
        h_stuck = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        op    = 2'b00;
        funct = 6'b0;
        mr    = 1'b0;

        do_reset(3);
        instr("dp_reg",  2'b00, 6'b000000, 0, 0);
        instr("ldr",     2'b01, 6'b000001, 0, 2);
        instr("str",     2'b01, 6'b000000, 0, 1);
        instr("branch",  2'b10, 6'b000000, 4, 0);
        instr("undef",   2'b11, 6'b000000, 0, 0);
        instr("dp_imm",  2'b00, 6'b100000, 1, 0);
        instr("ldr_z",   2'b01, 6'b100001, 0, 0);

        do_reset(2);
        for (int i = 0; i < 16; i++) instr($sformatf("br_wrap%0d", i), 2'b10, 6'($urandom_range(0,63)), 0, 0);
        instr("after_wrap", 2'b00, 6'b000000, 0, 0);

        // Abandon a store stalled in MEMWR: fetch, decode, memadr, 3 stall cycles.
        tag   = "str_abort";
        op    = 2'b01;
        funct = 6'b000000;
        build(2'b01, 6'b000000, 0, 10);
        run(6);
        plan.delete();
        do_reset(1);
        instr("post_abort", 2'b00, 6'b000000, 0, 0);

        for (int i = 0; i < 60; i++) begin
            instr($sformatf("rnd%0d", i), 2'($urandom_range(0,3)), 6'($urandom_range(0,63)),
                  $urandom_range(0,2), $urandom_range(0,3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
